rsa_modexp_encrypt: RTL and testbench
=====================================

RSA_MODEXP_ENCRYPT -- requirements
Module: rsa_modexp_encrypt

Interface
REQ-001 SHALL have parameter WIDTH, default 256, operand width in bits for M, E, N and C.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request to begin one encryption.
REQ-005 SHALL have port key_valid  input  1  key-validity flag from the key-check stage.
REQ-006 SHALL have port M  input  WIDTH  plaintext message.
REQ-007 SHALL have port E  input  WIDTH  public exponent.
REQ-008 SHALL have port N  input  WIDTH  modulus.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port done  output  1  single-cycle completion pulse.
REQ-011 SHALL have port error  output  1  qualifies done: operation rejected.
REQ-012 SHALL have port C  output  WIDTH  ciphertext = M^E mod N.

Function
REQ-013 SHALL use states IDLE, LOAD, SQR, MUL, DONE.
REQ-014 IDLE: start=1 at a clock edge SHALL latch M, E, N and key_valid into internal registers and move to LOAD; busy=1 from the next cycle.
REQ-015 Inputs M, E, N, key_valid SHALL be ignored after latching; start SHALL be ignored in any state other than IDLE.
REQ-016 LOAD (1 cycle): reject if latched key_valid=0, N<2, or M>=N -> DONE with error=1, C=0.
REQ-017 LOAD otherwise: set accumulator R=1, bit index i=WIDTH-1, go to SQR.
REQ-018 SQR: R <= R*R mod N via the bit-serial modular multiplier (REQ-021), exactly WIDTH cycles.
REQ-019 After SQR: if E[i]=1 go to MUL (R <= R*M mod N, WIDTH cycles); else skip MUL.
REQ-020 After SQR/MUL for bit i: if i=0 go to DONE; else i <= i-1, go to SQR. Leading zero bits of E are not skipped.
REQ-021 Modular multiplier, A*B mod N, MSB-first over A: per cycle P <= red(red(2P) + (A[k] ? B : 0)), where red(x)=x-N if x>=N else x; P starts at 0; internal width WIDTH+2; all intermediates < N.
REQ-022 DONE (1 cycle): done=1, C=R (or 0 on error), error as decided; busy=0 in this cycle; then IDLE.
REQ-023 C and error SHALL hold their values after done until the next accepted start, which clears error in LOAD.
REQ-024 Latency, valid path: done high in the cycle ending L = 2 + WIDTH*(WIDTH + popcount(E)) edges after the start-sampling edge.
REQ-025 Latency, error path: done high 2 edges after the start-sampling edge.
REQ-026 E=0 with valid operands SHALL give C=1.
REQ-027 M=0 with valid operands and E!=0 SHALL give C=0.
REQ-028 start=1 in the DONE cycle SHALL be ignored; start is accepted only in IDLE.

Reset
REQ-029 reset=0 at a clock edge SHALL force IDLE, busy=0, done=0, error=0, C=0, and clear all internal registers.
REQ-030 Reset SHALL take priority over start and abort any in-progress operation without a done pulse.
REQ-031 After reset deasserts, a new start SHALL be accepted on the first edge with start=1.

Verification
REQ-032 WIDTH=8, M=5, E=3, N=33, key_valid=1, pulse start -> done after 82 cycles, C=26, error=0.
REQ-033 WIDTH=8, E=0, M=7, N=33 -> C=1, latency 66 cycles; M=0, E=7, N=33 -> C=0, latency 90 cycles.
REQ-034 WIDTH=8, M=40, N=33 (also key_valid=0; also N=1) -> done after 2 cycles, error=1, C=0.
REQ-035 WIDTH=8, M=5, E=3, N=33: assert start and change M/E/N every cycle during busy -> no restart, C=26 at the 82-cycle done.
REQ-036 Drive reset=0 mid-SQR -> next cycle busy=0, no done pulse; a subsequent start with M=5, E=3, N=33 -> C=26.
REQ-037 WIDTH=256, M=2, E=17, N=1000003 -> C=131072, error=0, latency 2+256*258 cycles.

Source files
------------

// File: rtl/rsa_modexp_encrypt_if.sv
// Request/response bundle for rsa_modexp_encrypt.
//   master: drives start, key_valid, M, E, N; observes busy, done, error, C
//   slave : the encryption engine side
interface rsa_modexp_encrypt_if #(
  parameter int unsigned WIDTH = 256
);
  logic             start;
  logic             key_valid;
  logic [WIDTH-1:0] M;
  logic [WIDTH-1:0] E;
  logic [WIDTH-1:0] N;
  logic             busy;
  logic             done;
  logic             error;
  logic [WIDTH-1:0] C;

  modport master (
    output start, key_valid, M, E, N,
    input  busy, done, error, C
  );

  modport slave (
    input  start, key_valid, M, E, N,
    output busy, done, error, C
  );
endinterface

// File: rtl/rsa_modexp_encrypt.sv
// RSA encryption core: C = M^E mod N by left-to-right square-and-multiply
// over a bit-serial (MSB-first) modular multiplier.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-low reset
//   bus   - slave side of rsa_modexp_encrypt_if (start/key_valid/M/E/N in,
//           busy/done/error/C out, all outputs registered)
module rsa_modexp_encrypt #(
  parameter int unsigned WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  rsa_modexp_encrypt_if.slave   bus
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PW = WIDTH + 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SQR  = 3'd2,
    MUL  = 3'd3,
    DONE = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] e_q, e_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic             kv_q, kv_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [PW-1:0]    p_q, p_d;
  logic [IW-1:0]    k_q, k_d;
  logic [IW-1:0]    i_q, i_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [WIDTH-1:0] c_q, c_d;

  // One multiplier step: P <- red(red(2P) + (A[k] ? B : 0)), A = R always
  logic [PW-1:0] n_ext;
  logic [PW-1:0] b_ext;
  logic [PW-1:0] dbl;
  logic [PW-1:0] dbl_red;
  logic [PW-1:0] sum;
  logic [PW-1:0] step;

  always_comb begin
    n_ext   = PW'(n_q);
    b_ext   = (state_q == MUL) ? PW'(m_q) : PW'(r_q);
    dbl     = p_q << 1;
    dbl_red = (dbl >= n_ext) ? (dbl - n_ext) : dbl;
    sum     = dbl_red + (r_q[k_q] ? b_ext : '0);
    step    = (sum >= n_ext) ? (sum - n_ext) : sum;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    e_d     = e_q;
    n_d     = n_q;
    kv_d    = kv_q;
    r_d     = r_q;
    p_d     = p_q;
    k_d     = k_q;
    i_d     = i_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = error_q;
    c_d     = c_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          m_d     = bus.M;
          e_d     = bus.E;
          n_d     = bus.N;
          kv_d    = bus.key_valid;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end

      LOAD: begin
        error_d = 1'b0;
        if (!kv_q || (n_q < WIDTH'(2)) || (m_q >= n_q)) begin
          error_d = 1'b1;
          c_d     = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end else begin
          r_d     = WIDTH'(1);
          p_d     = '0;
          i_d     = IW'(WIDTH - 1);
          k_d     = IW'(WIDTH - 1);
          state_d = SQR;
        end
      end

      SQR, MUL: begin
        p_d = step;
        if (k_q == '0) begin
          // Product complete: commit and pick the next operation
          r_d = WIDTH'(step);
          p_d = '0;
          k_d = IW'(WIDTH - 1);
          if ((state_q == SQR) && e_q[i_q]) begin
            state_d = MUL;
          end else if (i_q == '0) begin
            c_d     = WIDTH'(step);
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end else begin
            i_d     = i_q - IW'(1);
            state_d = SQR;
          end
        end else begin
          k_d = k_q - IW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      m_q     <= '0;
      e_q     <= '0;
      n_q     <= '0;
      kv_q    <= 1'b0;
      r_q     <= '0;
      p_q     <= '0;
      k_q     <= '0;
      i_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      c_q     <= '0;
    end else begin
      m_q     <= m_d;
      e_q     <= e_d;
      n_q     <= n_d;
      kv_q    <= kv_d;
      r_q     <= r_d;
      p_q     <= p_d;
      k_q     <= k_d;
      i_q     <= i_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      c_q     <= c_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.error = error_q;
  assign bus.C     = c_q;

endmodule

// File: tb/tb_rsa_modexp_encrypt.sv
// Self-checking bench for rsa_modexp_encrypt (WIDTH=8 and WIDTH=256 instances).
module tb_rsa_modexp_encrypt;

  logic clk;
  logic reset;

  rsa_modexp_encrypt_if #(.WIDTH(8))   bus8();
  rsa_modexp_encrypt_if #(.WIDTH(256)) bus256();

  rsa_modexp_encrypt #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  rsa_modexp_encrypt #(.WIDTH(256)) dut256 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus256)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int passed;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else passed++;
  endtask

  // Reference: right-to-left binary exponentiation on plain integers
  function automatic void model(input longint unsigned m, input longint unsigned e,
                                input longint unsigned n, input bit kv, input int w,
                                output longint unsigned c, output bit err, output int lat);
    longint unsigned r, b, ee;
    err = !kv || (n < 2) || (m >= n);
    if (err) begin
      c   = 0;
      lat = 2;
    end else begin
      r  = 1;
      b  = m % n;
      ee = e;
      while (ee != 0) begin
        if (ee[0]) r = (r * b) % n;
        b  = (b * b) % n;
        ee = ee >> 1;
      end
      c   = r % n;
      lat = 2 + w * (w + $countones(e));
    end
  endfunction

  // Runs one 8-bit operation; lat counts edges from the start-sampling edge
  // to the edge that ends the done cycle.
  task automatic run8(input logic [7:0] m, input logic [7:0] e, input logic [7:0] n,
                      input logic kv, input bit scramble,
                      output logic [7:0] c, output logic err, output int lat);
    bit to;
    @(negedge clk);
    bus8.M = m; bus8.E = e; bus8.N = n; bus8.key_valid = kv; bus8.start = 1'b1;
    @(posedge clk); #1;
    if (scramble) begin
      bus8.M = 8'($urandom); bus8.E = 8'($urandom); bus8.N = 8'($urandom);
      bus8.key_valid = 1'($urandom);
    end else begin
      bus8.start = 1'b0;
    end
    check("busy_after_start", 256'(bus8.busy), 256'(1));
    lat = 1;
    to  = 1'b0;
    while (!bus8.done) begin
      if (lat >= 300) begin to = 1'b1; break; end
      @(posedge clk); #1;
      lat++;
      if (!bus8.done && scramble) begin
        bus8.M = 8'($urandom); bus8.E = 8'($urandom); bus8.N = 8'($urandom);
        bus8.key_valid = 1'($urandom);
      end
    end
    check("done_timeout", 256'(to), 256'(0));
    c   = bus8.C;
    err = bus8.error;
    check("busy_in_done", 256'(bus8.busy), 256'(0));
    // start may still be high here: it must be ignored in the done cycle
    @(posedge clk); #1;
    bus8.start = 1'b0;
    check("done_single_pulse", 256'(bus8.done), 256'(0));
    check("no_restart", 256'(bus8.busy), 256'(0));
    check("c_hold", 256'(bus8.C), 256'(c));
    check("err_hold", 256'(bus8.error), 256'(err));
  endtask

  typedef struct {
    logic [7:0] m;
    logic [7:0] e;
    logic [7:0] n;
    logic       kv;
    logic [7:0] c;
    logic       err;
    int         lat;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [7:0]      c8;
    logic            err8;
    int              lat8;
    longint unsigned mc;
    bit              merr;
    int              mlat;
    logic [7:0]      rm, re, rn;
    logic            rkv;
    bit              to;
    int              lat;
    bit              saw_done;

    total  = 0;
    passed = 0;

    tbl[0] = '{m:8'd5,   e:8'd3,   n:8'd33,  kv:1'b1, c:8'd26,  err:1'b0, lat:82};
    tbl[1] = '{m:8'd7,   e:8'd0,   n:8'd33,  kv:1'b1, c:8'd1,   err:1'b0, lat:66};
    tbl[2] = '{m:8'd0,   e:8'd7,   n:8'd33,  kv:1'b1, c:8'd0,   err:1'b0, lat:90};
    tbl[3] = '{m:8'd40,  e:8'd3,   n:8'd33,  kv:1'b1, c:8'd0,   err:1'b1, lat:2};
    tbl[4] = '{m:8'd5,   e:8'd3,   n:8'd33,  kv:1'b0, c:8'd0,   err:1'b1, lat:2};
    tbl[5] = '{m:8'd5,   e:8'd3,   n:8'd1,   kv:1'b1, c:8'd0,   err:1'b1, lat:2};
    tbl[6] = '{m:8'd33,  e:8'd1,   n:8'd33,  kv:1'b1, c:8'd0,   err:1'b1, lat:2};
    tbl[7] = '{m:8'd32,  e:8'd5,   n:8'd33,  kv:1'b1, c:8'd32,  err:1'b0, lat:82};
    tbl[8] = '{m:8'd2,   e:8'd255, n:8'd255, kv:1'b1, c:8'd128, err:1'b0, lat:130};
    tbl[9] = '{m:8'd0,   e:8'd0,   n:8'd2,   kv:1'b1, c:8'd1,   err:1'b0, lat:66};

    bus8.start = 1'b0; bus8.key_valid = 1'b0; bus8.M = '0; bus8.E = '0; bus8.N = '0;
    bus256.start = 1'b0; bus256.key_valid = 1'b0; bus256.M = '0; bus256.E = '0; bus256.N = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 256'(bus8.busy), 256'(0));
    check("rst_done", 256'(bus8.done), 256'(0));
    check("rst_error", 256'(bus8.error), 256'(0));
    check("rst_c", 256'(bus8.C), 256'(0));
    check("rst_busy_256", 256'(bus256.busy), 256'(0));
    check("rst_c_256", bus256.C, 256'(0));
    @(negedge clk);
    reset = 1'b1;

    // Directed table
    for (int t = 0; t < 10; t++) begin
      run8(tbl[t].m, tbl[t].e, tbl[t].n, tbl[t].kv, 1'b0, c8, err8, lat8);
      check($sformatf("tbl%0d_c", t),   256'(c8),   256'(tbl[t].c));
      check($sformatf("tbl%0d_err", t), 256'(err8), 256'(tbl[t].err));
      check($sformatf("tbl%0d_lat", t), 256'(lat8), 256'(tbl[t].lat));
    end

    // Randomized operands against the reference model
    for (int t = 0; t < 20; t++) begin
      rn  = 8'($urandom);
      rm  = 8'($urandom);
      if (($urandom % 4 != 0) && (rn != 0)) rm = rm % rn;
      re  = 8'($urandom);
      rkv = ($urandom_range(0, 7) != 0);
      model(64'(rm), 64'(re), 64'(rn), rkv, 8, mc, merr, mlat);
      run8(rm, re, rn, rkv, 1'b0, c8, err8, lat8);
      check($sformatf("rnd%0d_c", t),   256'(c8),   256'(mc));
      check($sformatf("rnd%0d_err", t), 256'(err8), 256'(merr));
      check($sformatf("rnd%0d_lat", t), 256'(lat8), 256'(mlat));
    end

    // Inputs churn and start held high throughout the operation
    run8(8'd5, 8'd3, 8'd33, 1'b1, 1'b1, c8, err8, lat8);
    check("scramble_c",   256'(c8),   256'(26));
    check("scramble_err", 256'(err8), 256'(0));
    check("scramble_lat", 256'(lat8), 256'(82));

    // Reset in the middle of a squaring pass
    @(negedge clk);
    bus8.M = 8'd5; bus8.E = 8'd3; bus8.N = 8'd33; bus8.key_valid = 1'b1; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    saw_done = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus8.done) saw_done = 1'b1;
    end
    check("pre_reset_busy", 256'(bus8.busy), 256'(1));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    if (bus8.done) saw_done = 1'b1;
    check("abort_busy", 256'(bus8.busy), 256'(0));
    check("abort_done", 256'(bus8.done), 256'(0));
    check("abort_error", 256'(bus8.error), 256'(0));
    check("abort_c", 256'(bus8.C), 256'(0));
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus8.done) saw_done = 1'b1;
    end
    check("abort_no_done", 256'(saw_done), 256'(0));
    run8(8'd5, 8'd3, 8'd33, 1'b1, 1'b0, c8, err8, lat8);
    check("post_reset_c",   256'(c8),   256'(26));
    check("post_reset_lat", 256'(lat8), 256'(82));

    // Full-width operation
    model(64'd2, 64'd17, 64'd1000003, 1'b1, 256, mc, merr, mlat);
    @(negedge clk);
    bus256.M = 256'(2); bus256.E = 256'(17); bus256.N = 256'(1000003);
    bus256.key_valid = 1'b1; bus256.start = 1'b1;
    @(posedge clk); #1;
    bus256.start = 1'b0;
    lat = 1;
    to  = 1'b0;
    while (!bus256.done) begin
      if (lat >= 70000) begin to = 1'b1; break; end
      @(posedge clk); #1;
      lat++;
    end
    check("w256_timeout", 256'(to), 256'(0));
    check("w256_c",   bus256.C,            256'(mc));
    check("w256_c_k", bus256.C,            256'(131072));
    check("w256_err", 256'(bus256.error),  256'(merr));
    check("w256_lat", 256'(lat),           256'(mlat));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
